// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer behind the UART receiver: good bytes are visible on m_data one edge after the frame event.
// A stalled consumer backs up the FIFO; when it is full, new bytes are dropped and overflow is latched.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_parity,
  input  logic                     rx_ready,
  input  logic                     rx_error,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [ERR_W-1:0]         err_count,
  input  logic                     clr
);

  localparam int AW = $clog2(DEPTH);

  logic          rdy_q;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          ev;
  logic          empty;
  logic          full;
  logic          push;
  logic          drop;
  logic          err_ev;
  logic          pop;
  logic          unused_parity;

  // Parity is already judged by the receiver; only its verdict matters here.
  assign unused_parity = rx_parity;

  assign ev     = rx_ready & ~rdy_q;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign err_ev = ev & rx_error;
  assign push   = ev & ~rx_error & ~full;
  assign drop   = ev & ~rx_error & full;
  assign pop    = m_valid & m_ready;

  assign m_valid = ~empty;
  assign level   = wr_ptr - rd_ptr;
  assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // rdy_q resets high so a frame completed before reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rx_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (clr)       overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;

      if (clr)                              err_count <= '0;
      else if (err_ev && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; a second instance with a narrow error counter covers saturation.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_parity;
  logic       rx_ready;
  logic       rx_error;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] err_count;
  logic       clr;

  logic       s_ready;
  logic       s_error;
  logic [1:0] s_err_count;
  logic [7:0] s_unused_data;
  logic       s_unused_valid;
  logic [4:0] s_unused_level;
  logic       s_unused_ovf;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [$];
  logic [7:0] exp_b;

  uart_rx_fifo #(.DEPTH(16), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_parity(rx_parity),
    .rx_ready(rx_ready), .rx_error(rx_error), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .level(level), .overflow(overflow), .err_count(err_count), .clr(clr)
  );

  uart_rx_fifo #(.DEPTH(16), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .rx_data(8'h00), .rx_parity(1'b0),
    .rx_ready(s_ready), .rx_error(s_error), .m_data(s_unused_data), .m_valid(s_unused_valid),
    .m_ready(1'b0), .level(s_unused_level), .overflow(s_unused_ovf), .err_count(s_err_count),
    .clr(1'b0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: event edge with rx_ready high, then a cycle low to re-arm the detector.
  task automatic frame(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_error = e;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_error = 1'b0;
    tick();
  endtask

  task automatic sat_err_frame();
    s_error = 1'b1;
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    s_error = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_parity = 1'b0; rx_ready = 1'b0; rx_error = 1'b0;
    m_ready = 1'b0; clr = 1'b0; s_ready = 1'b0; s_error = 1'b0;
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_m_data", m_data, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic ordering with a stalled consumer.
    frame(8'hA5, 1'b0);
    chk("first_write_valid", m_valid, 1);
    frame(8'h3C, 1'b0);
    frame(8'h00, 1'b0);
    chk("three_level", level, 3);
    chk("three_head", m_data, 8'hA5);
    m_ready = 1'b1;
    chk("pop0_data", m_data, 8'hA5);
    tick();
    chk("pop1_data", m_data, 8'h3C);
    tick();
    chk("pop2_data", m_data, 8'h00);
    chk("pop2_valid", m_valid, 1);
    tick();
    m_ready = 1'b0;
    chk("drained_valid", m_valid, 0);
    chk("drained_level", level, 0);

    // Long rx_ready level produces exactly one write.
    rx_data  = 8'h5A;
    rx_ready = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    rx_ready = 1'b0;
    tick();
    chk("hold_level", level, 1);
    chk("hold_data", m_data, 8'h5A);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("hold_drained", level, 0);

    // Parity-error frames are counted, not stored.
    frame(8'h11, 1'b0);
    frame(8'hFF, 1'b1);
    frame(8'hEE, 1'b1);
    frame(8'h22, 1'b0);
    chk("err_count2", err_count, 2);
    chk("err_level", level, 2);
    chk("err_head0", m_data, 8'h11);
    m_ready = 1'b1;
    tick();
    chk("err_head1", m_data, 8'h22);
    tick();
    m_ready = 1'b0;
    chk("err_drained", level, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("err_clr", err_count, 0);
    clr = 1'b1;
    rx_error = 1'b1;
    rx_ready = 1'b1;
    tick();
    clr = 1'b0;
    rx_error = 1'b0;
    rx_ready = 1'b0;
    chk("clr_beats_err", err_count, 0);
    tick();

    // Saturation of a 2-bit counter.
    for (int i = 0; i < 3; i++) sat_err_frame();
    chk("sat_at3", s_err_count, 3);
    sat_err_frame();
    sat_err_frame();
    chk("sat_hold", s_err_count, 3);

    // Overflow: 17 frames into 16 entries.
    for (int i = 0; i < 16; i++) frame(8'(i), 1'b0);
    chk("full_level", level, 16);
    chk("full_no_ovf", overflow, 0);
    frame(8'h10, 1'b0);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", m_data, 8'(i));
      tick();
    end
    m_ready = 1'b0;
    chk("ovf_empty", m_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Full FIFO: clr beats a same-cycle drop; then simultaneous push and pop.
    for (int i = 0; i < 16; i++) begin
      frame(8'h20 + 8'(i), 1'b0);
      model.push_back(8'h20 + 8'(i));
    end
    clr = 1'b1;
    frame(8'hDD, 1'b0);
    clr = 1'b0;
    chk("clr_beats_ovf", overflow, 0);
    chk("clr_ovf_level", level, 16);
    rx_data  = 8'hEE;
    rx_ready = 1'b1;
    m_ready  = 1'b1;
    tick();
    rx_ready = 1'b0;
    m_ready  = 1'b0;
    void'(model.pop_front());
    chk("fullpp_level", level, 15);
    chk("fullpp_ovf", overflow, 1);
    chk("fullpp_head", m_data, 8'h21);
    tick();
    for (int k = 0; k < 20; k++) begin
      exp_b = model.pop_front();
      chk("wrap_head", m_data, exp_b);
      model.push_back(8'h40 + 8'(k));
      rx_data  = 8'h40 + 8'(k);
      rx_ready = 1'b1;
      m_ready  = 1'b1;
      tick();
      rx_ready = 1'b0;
      m_ready  = 1'b0;
      chk("wrap_level", level, 15);
      tick();
    end
    m_ready = 1'b1;
    while (model.size() > 0) begin
      exp_b = model.pop_front();
      chk("wrap_drain", m_data, exp_b);
      tick();
    end
    m_ready = 1'b0;
    chk("wrap_empty", m_valid, 0);

    // rx_ready already high when reset releases: no write.
    rst_n = 1'b0;
    rx_data = 8'h77;
    rx_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("pre_rst_level", level, 0);
    chk("pre_rst_valid", m_valid, 0);
    rx_ready = 1'b0;
    tick();

    // Asynchronous reset with occupancy 5.
    for (int i = 0; i < 5; i++) frame(8'h60 + 8'(i), 1'b0);
    chk("lvl5", level, 5);
    rst_n = 1'b0;
    #2;
    chk("async_valid", m_valid, 0);
    chk("async_level", level, 0);
    chk("async_data", m_data, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver controller, in the same `clk` domain. It detects each completed frame from the receiver's level-style `ready`/`error` outputs and pushes good bytes into a first-word-fall-through FIFO. Bytes with parity errors are dropped and counted. Bytes that arrive while the FIFO is full are dropped and flagged. A consumer drains the FIFO through a valid/ready handshake.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `ERR_W`, 8, width of the parity-error counter.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the receiver; valid only on a good-frame event.
- `rx_parity`  in  1  received parity bit; not stored.
- `rx_ready`  in  1  receiver frame-done level; held high until the next start bit is qualified.
- `rx_error`  in  1  receiver parity-error level; meaningful when `rx_ready`=1.
- `m_data`  out  8  head-of-FIFO byte; valid when `m_valid`=1.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts the head byte.
- `level`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `err_count`  out  ERR_W  saturating count of parity-error frames.
- `clr`  in  1  synchronous clear of `overflow` and `err_count`. Does not flush the FIFO.

## Operation
- Edge detector: register `rdy_q` <= `rx_ready`; `rdy_q` resets to 1. Frame event `ev` = `rx_ready` & ~`rdy_q`.
  - Because `rdy_q` resets to 1, a frame that completed before reset release is not captured.
  - Exactly one event occurs per rising edge of `rx_ready`, however long `rx_ready` stays high.
- On `ev`, decide using the state sampled at the start of the cycle:
  - If `rx_error`=1: `err_count` increments, saturating at 2^ERR_W−1. Nothing is written. `rx_data` is ignored, because it is undefined on error.
  - Else if the FIFO is full: the byte is dropped and `overflow` is set to 1.
  - Else: `rx_data` is written at `wr_ptr`, and `wr_ptr` increments.
- Pop: when `m_valid` & `m_ready`, `rd_ptr` increments.
- Pointers are log2(DEPTH)+1 bits wide, with the extra bit used for wrap.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - `level` = `wr_ptr` − `rd_ptr`, modulo 2^(log2(DEPTH)+1).
- Push and pop in the same cycle:
  - Not full and not empty: both occur and `level` is unchanged.
  - Full: the push is dropped (full is judged before the pop) and `overflow` is set; the pop still occurs, so `level` = DEPTH−1.
  - Empty: only the push occurs, since `m_valid` was 0.
- `clr` has priority over an error event in the same cycle: `err_count` becomes 0, not 1. `clr` also has priority over an overflow in the same cycle: `overflow` becomes 0.
- `m_data` = `mem[rd_ptr]` (FWFT). It is 8'h00 after reset until the first write.
- Storage is a plain register array with no reset requirement. Pointers, `rdy_q`, `overflow` and `err_count` are asynchronously reset.

## Timing
- Reset values:
  - `m_valid`=0, `level`=0, `overflow`=0, `err_count`=0, `m_data`=8'h00.
  - Internal: `rdy_q`=1, pointers=0.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous) and discards all contents.
- Write latency: let edge N be the first edge that samples `rx_ready`=1 while `rdy_q`=0. The byte is written at edge N. `m_valid`=1 and `m_data` is valid immediately after edge N.
- Pop: the entry is removed at the edge where `m_valid` & `m_ready` is sampled. The next entry appears on `m_data` in the same cycle the pointer updates, so there is zero bubble.
- `m_ready` may be held high continuously. At most one pop occurs per cycle.
- `level`, `overflow` and `err_count` update at the same edge as the causing event.
- Sustained throughput: one byte per frame, which is far below one byte per cycle. The FIFO never limits the receiver; only a stalled consumer can.

## Test plan
- Reset, then 3 good frames 8'hA5, 8'h3C, 8'h00 with `m_ready`=0 → `level`=3, `m_data`=8'hA5. Then `m_ready`=1 for 3 cycles → output A5, 3C, 00 in order, then `m_valid`=0 and `level`=0.
- `rx_ready` held high for 50 cycles after one frame 8'h5A → exactly one entry written, `level`=1.
- 2 frames with `rx_error`=1 between 2 good frames 8'h11, 8'h22 → `err_count`=2, FIFO contains only 11, 22. With ERR_W=2 and 5 error frames → `err_count` saturates at 3.
- DEPTH=16 with `m_ready`=0 and 17 good frames 8'h00..8'h10 → `level`=16, `overflow`=1. Draining yields 00..0F; 8'h10 is absent. Then `clr` → `overflow`=0.
- Full FIFO, with good frame event and pop in the same cycle → `level`=15 and `overflow`=1. Then 20 push/pop cycles past the wrap point → data order is preserved.
- `rx_ready` already high when `rst_n` deasserts → no write. Reset asserted with `level`=5 → `m_valid`=0 and `level`=0 asynchronously, before the next `clk` edge.
